capture_readout: RTL and testbench

- Downstream of the logic capture stage. Once a capture completes, it drains the capture RAM in chronological order, starting at the oldest stored sample and wrapping around the circular buffer.
- Emits the samples as a byte stream with a valid/ready handshake toward the host link (UART/USB bridge).
- Handles the 1-cycle synchronous RAM read latency and consumer backpressure without losing or duplicating samples.

---
 rtl/capture_pkg.sv | 24 ++
 rtl/readout_skid.sv | 80 ++++++++
 rtl/capture_readout.sv | 249 ++++++++++++++++++++++++
 tb/tb_capture_readout.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and helpers for the capture readout block: FSM encoding,
// header sync byte and the circular-buffer address wrap.
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    FETCH = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_e;

  localparam logic [7:0] HEADER_SYNC = 8'hA5;

  // Successor address in a circular buffer of the given depth.
  function automatic logic [31:0] wrap_next(input logic [31:0] addr, input logic [31:0] depth);
    if (addr == depth - 32'd1) begin
      return 32'd0;
    end else begin
      return addr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/readout_skid.sv
// Two-entry valid/ready buffer. The head entry is the registered stream output;
// slots_free reports the room left once this cycle's pop is accounted for.
module readout_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [1:0]        slots_free
);

  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              valid_q, valid_d;
  logic              pop;

  assign pop        = valid_q && out_ready;
  assign slots_free = 2'd2 - occ_q + {1'b0, pop};
  assign out_data   = head_q;
  assign out_valid  = valid_q;

  // Next occupancy and entry contents; the head only moves on a pop or into an empty buffer.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      case ({wr_en, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_d = wr_data;
          end else begin
            tail_d = wr_data;
          end
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_d = wr_data;
          end else begin
            head_d = tail_q;
            tail_d = wr_data;
          end
        end
        default: begin
          occ_d = occ_q;
        end
      endcase
    end
    valid_d = (occ_d != 2'd0);
  end

  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/capture_readout.sv
// Drains the circular capture RAM oldest-first into a valid/ready byte stream.
// Define READOUT_HEADER_EN to prefix each readout with a 4-byte header.
module capture_readout
  import capture_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 262144
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] left_q, left_d;
  logic [ADDR_W-1:0] beats_q, beats_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              addr_ok, rd_en, pop, last_beat, flush, skid_wr;
  logic [DATA_W-1:0] skid_din;
  logic [1:0]        slots_free;

`ifdef READOUT_HEADER_EN
  logic [1:0]        hdr_idx_q, hdr_idx_d;
  logic [2:0]        hdr_left_q, hdr_left_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [23:0]       len24;
  logic [7:0]        hdr_byte;
  logic              hdr_push;

  assign len24     = 24'(len_q);
  assign hdr_push  = (state_q == HDR) && (slots_free != 2'd0);
  assign skid_wr   = pend_q || hdr_push;
  assign skid_din  = pend_q ? ram_dout : DATA_W'(hdr_byte);
  assign last_beat = pop && (((hdr_left_q == 3'd0) && (beats_q == ONE)) ||
                             ((hdr_left_q == 3'd1) && (beats_q == '0)));

  // Header byte selection.
  always_comb begin
    case (hdr_idx_q)
      2'd0:    hdr_byte = HEADER_SYNC;
      2'd1:    hdr_byte = len24[7:0];
      2'd2:    hdr_byte = len24[15:8];
      default: hdr_byte = len24[23:16];
    endcase
  end
`else
  assign skid_wr   = pend_q;
  assign skid_din  = ram_dout;
  assign last_beat = pop && (beats_q == ONE);
`endif

  assign addr_ok = 32'(start_addr) < 32'(DEPTH);
  assign pop     = out_valid && out_ready;
  // A read may issue only if its data still fits once the read already in flight lands.
  assign rd_en   = (state_q == FETCH) && (left_q != '0) && (slots_free > {1'b0, pend_q});

  assign ram_en   = rd_en;
  assign ram_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    beats_d = beats_q;
    pend_d  = rd_en;
    done_d  = 1'b0;
    err_d   = 1'b0;
    flush   = 1'b0;
`ifdef READOUT_HEADER_EN
    hdr_idx_d  = hdr_idx_q;
    hdr_left_d = hdr_left_q;
    len_d      = len_q;
`endif

    if (rd_en) begin
      addr_d = ADDR_W'(wrap_next(32'(addr_q), 32'(DEPTH)));
      left_d = left_q - ONE;
    end else begin
      left_d = left_q;
    end

`ifdef READOUT_HEADER_EN
    if (pop && (hdr_left_q != 3'd0)) begin
      hdr_left_d = hdr_left_q - 3'd1;
    end else if (pop) begin
      beats_d = beats_q - ONE;
    end else begin
      beats_d = beats_q;
    end
`else
    if (pop) begin
      beats_d = beats_q - ONE;
    end else begin
      beats_d = beats_q;
    end
`endif

    case (state_q)
      IDLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start && !addr_ok) begin
          err_d = 1'b1;
`ifdef READOUT_HEADER_EN
        end else if (start) begin
          addr_d     = start_addr;
          left_d     = count;
          beats_d    = count;
          len_d      = count;
          hdr_idx_d  = 2'd0;
          hdr_left_d = 3'd4;
          state_d    = HDR;
`else
        end else if (start && (count == '0)) begin
          done_d = 1'b1;
        end else if (start) begin
          addr_d  = start_addr;
          left_d  = count;
          beats_d = count;
          state_d = FETCH;
`endif
        end else begin
          state_d = IDLE;
        end
      end
`ifdef READOUT_HEADER_EN
      HDR: begin
        if (hdr_push) begin
          hdr_idx_d = hdr_idx_q + 2'd1;
          if (hdr_idx_q == 2'd3) begin
            state_d = (len_q == '0) ? DRAIN : FETCH;
          end else begin
            state_d = HDR;
          end
        end else begin
          state_d = HDR;
        end
      end
`endif
      FETCH: begin
        if (rd_en && (left_q == ONE)) begin
          state_d = DRAIN;
        end else begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (last_beat) begin
          state_d = FIN;
        end else begin
          state_d = DRAIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort drops everything, including a read whose data has not landed yet.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      flush   = 1'b1;
      pend_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      flush = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      beats_q <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      beats_q <= beats_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

`ifdef READOUT_HEADER_EN
  // Header sequencing registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_idx_q  <= 2'd0;
      hdr_left_q <= 3'd0;
      len_q      <= '0;
    end else begin
      hdr_idx_q  <= hdr_idx_d;
      hdr_left_q <= hdr_left_d;
      len_q      <= len_d;
    end
  end
`endif

  readout_skid #(.DATA_W(DATA_W)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .wr_en      (skid_wr),
    .wr_data    (skid_din),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .slots_free (slots_free)
  );

endmodule

// File: tb/tb_capture_readout.sv
// Randomized scoreboard bench for capture_readout with a 16-entry RAM model.
module tb_capture_readout;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset, start, abort, out_ready;
  logic [ADDR_W-1:0] start_addr, count;
  logic              busy, done, err, ram_en, out_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout = '0;
  logic [DATA_W-1:0] out_data;

  capture_readout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .count(count),
    .abort(abort), .busy(busy), .done(done), .err(err), .ram_en(ram_en),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [DEPTH];
  logic [7:0] exp_q [$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, rmode = 0, pidx = 0;
  int done_cnt = 0, err_cnt = 0, ren_cnt = 0, beats_seen = 0;
  int first_beat_cyc = -1, last_beat_cyc = 0, done_cyc = 0;
  bit stall_prev = 1'b0, disturb_prev = 1'b1;
  logic [7:0] prev_data = '0;
  int pat [6] = '{1, 0, 0, 1, 0, 1};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_en) ram_dout <= mem[ram_addr[3:0]];
  end

  // Consumer ready pattern.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1:       out_ready = ($urandom_range(0, 1) != 0);
        2:       begin out_ready = (pat[pidx] != 0); pidx = (pidx + 1) % 6; end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset) begin
      if (ram_en) begin
        check("ram_addr_range", 64'(ram_addr < ADDR_W'(DEPTH)), 64'd1);
        ren_cnt++;
      end
      if (stall_prev && !disturb_prev)
        check("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {1'b1, out_data}, 9'h0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", out_data, e);
        end
        beats_seen++;
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", busy, 1'b0);
      end
      if (err) err_cnt++;
    end
    stall_prev   = out_valid && !out_ready;
    prev_data    = out_data;
    disturb_prev = abort || reset;
  end

  task automatic push_expected(input int sa, input int cnt);
    logic [23:0] c24;
    c24 = 24'(cnt);
`ifdef READOUT_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(c24[7:0]);
    exp_q.push_back(c24[15:8]);
    exp_q.push_back(c24[23:16]);
`endif
    for (int k = 0; k < cnt; k++) exp_q.push_back(mem[(sa + k) % DEPTH]);
  endtask

  task automatic pulse_start(input int sa, input int cnt, output int n0);
    @(posedge clk); #1;
    start = 1'b1; start_addr = ADDR_W'(sa); count = ADDR_W'(cnt); n0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input int sa, input int cnt, input int mode, input bit poke);
    int n0, d0, e0, t;
    rmode = mode;
    push_expected(sa, cnt);
    d0 = done_cnt; e0 = err_cnt; first_beat_cyc = -1;
    pulse_start(sa, cnt, n0);
    check("busy_after_start", busy, 1'b1);
`ifndef READOUT_HEADER_EN
    check("first_read", {ram_en, ram_addr}, {1'b1, ADDR_W'(sa)});
`endif
    if (poke) begin
      start = 1'b1; start_addr = ADDR_W'(DEPTH); count = ADDR_W'(3);
      @(posedge clk); #1;
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 4000) begin @(posedge clk); t++; end
    check("done_seen", 64'(done_cnt - d0), 64'd1);
    check("all_beats", 64'(exp_q.size()), 64'd0);
    check("no_err", 64'(err_cnt), 64'(e0));
    check("done_after_last", 64'(done_cyc), 64'(last_beat_cyc + 2));
    if (mode == 0) begin
`ifdef READOUT_HEADER_EN
      check("first_beat_lat", 64'(first_beat_cyc), 64'(n0 + 2));
`else
      check("first_beat_lat", 64'(first_beat_cyc), 64'(n0 + 3));
      check("throughput", 64'(last_beat_cyc - first_beat_cyc), 64'(cnt - 1));
`endif
    end
    exp_q.delete();
    @(posedge clk); #1;
    check("idle_after", busy, 1'b0);
  endtask

  task automatic wait_beats(input int target, input string nm);
    int t;
    t = 0;
    while (beats_seen < target && t < 400) begin @(posedge clk); t++; end
    check(nm, 64'(beats_seen >= target), 64'd1);
  endtask

  initial begin
    int n0, d0, e0, r0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    reset = 1'b1; start = 1'b0; abort = 1'b0; start_addr = '0; count = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_state", {busy, done, err, ram_en, out_valid, ram_addr, out_data}, 23'd0);

    run(3, 5, 0, 1'b0);
    run(14, 4, 0, 1'b0);
    run(9, 6, 2, 1'b0);
    run(5, 258, 0, 1'b0);
    run(1, 20, 1, 1'b1);
    for (int r = 0; r < 8; r++)
      run($urandom_range(0, DEPTH - 1), $urandom_range(1, 40), $urandom_range(0, 2), 1'b0);

    // Abort after two beats, then a clean restart.
    rmode = 0;
    push_expected(7, 10);
    d0 = done_cnt;
    pulse_start(7, 10, n0);
    wait_beats(beats_seen + 2, "abort_wait");
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_outputs", {busy, out_valid, ram_en}, 3'b000);
    exp_q.delete();
    repeat (6) @(posedge clk);
    #1 check("abort_no_done", 64'(done_cnt), 64'(d0));
    run(11, 7, 0, 1'b0);

    // Abort together with start in IDLE: nothing happens.
    d0 = done_cnt; e0 = err_cnt; r0 = ren_cnt;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; start_addr = ADDR_W'(2); count = ADDR_W'(5);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 1'b0);
    repeat (4) @(posedge clk);
    #1 check("abort_start_quiet", {64'(ren_cnt - r0) + 64'(done_cnt - d0) + 64'(err_cnt - e0)}, 64'd0);

    // Out-of-range start address.
    d0 = done_cnt; e0 = err_cnt; r0 = ren_cnt;
    pulse_start(DEPTH, 3, n0);
    check("err_pulse", {err, busy, done}, 3'b100);
    repeat (3) @(posedge clk);
    #1 check("err_once", 64'(err_cnt - e0), 64'd1);
    check("err_quiet", 64'(ren_cnt - r0) + 64'(done_cnt - d0), 64'd0);

    // Zero-length readout.
`ifdef READOUT_HEADER_EN
    run(5, 0, 0, 1'b0);
`else
    d0 = done_cnt; r0 = ren_cnt;
    pulse_start(5, 0, n0);
    check("zero_done", {done, busy}, 2'b10);
    repeat (3) @(posedge clk);
    #1 check("zero_no_read", 64'(ren_cnt), 64'(r0));
    check("zero_one_done", 64'(done_cnt - d0), 64'd1);
`endif

    // Reset in the middle of a run.
    rmode = 0;
    push_expected(4, 20);
    pulse_start(4, 20, n0);
    wait_beats(beats_seen + 3, "reset_wait");
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_mid", {busy, done, err, ram_en, out_valid, ram_addr, out_data}, 23'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    run(0, 16, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
